register_file_mp: RTL and testbench

- Parametrised multi-port successor to the single-write, dual-read 64x64 register file.
- Generalises data width, depth, and the number of read and write ports.
- Adds asynchronous reset, registered reads with a valid flag, write-to-read bypass, optional hardwired zero register, and deterministic multi-write priority.
- Sits in the datapath between decode (read addresses) and writeback (write ports).

---
 rtl/rf_pkg.sv | 16 +
 rtl/rf_write_resolve.sv | 33 +++
 rtl/register_file_mp.sv | 103 ++++++++++
 tb/tb_register_file_mp.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package rf_pkg;

    localparam int RF_DATA_W = 64;
    localparam int RF_DEPTH  = 64;
    localparam int RF_NUM_RD = 2;
    localparam int RF_NUM_WR = 1;

    // A single-entry file still needs a one-bit address bus.
    function automatic int rf_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/rf_write_resolve.sv
// Resolves same-edge writes against a set of query addresses; the highest-index
// write port that matches a query wins.
module rf_write_resolve
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = rf_addr_w(RF_DEPTH),
    parameter int NUM_WR = RF_NUM_WR,
    parameter int NUM_Q  = 1
) (
    input  logic [NUM_WR-1:0]        i_wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
    input  logic [NUM_Q*ADDR_W-1:0]  i_q_addr,
    output logic [NUM_Q-1:0]         o_q_hit,
    output logic [NUM_Q*DATA_W-1:0]  o_q_data
);

    always_comb begin
        o_q_hit  = '0;
        o_q_data = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            // Ascending scan: a later match overrides, so the top port wins.
            for (int w = 0; w < NUM_WR; w++) begin
                if (i_wr_en[w] && (i_wr_addr[w*ADDR_W +: ADDR_W] == i_q_addr[q*ADDR_W +: ADDR_W])) begin
                    o_q_hit[q]                  = 1'b1;
                    o_q_data[q*DATA_W +: DATA_W] = i_wr_data[w*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file: registered reads with valid flag,
// optional write-first bypass and hardwired zero entry.
module register_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int NUM_WR   = RF_NUM_WR,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int ADDR_W  = rf_addr_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data
);

    // Queries 0..DEPTH-1 are the entries themselves; the rest are read ports.
    localparam int NUM_Q = DEPTH + NUM_RD;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0]       r_mem [DEPTH];
    logic [NUM_RD*DATA_W-1:0] r_rd_data;
    logic [NUM_RD-1:0]        r_rd_valid;

    logic [NUM_Q*ADDR_W-1:0]  w_q_addr;
    logic [NUM_Q-1:0]         w_q_hit;
    logic [NUM_Q*DATA_W-1:0]  w_q_data;
    logic [NUM_RD*DATA_W-1:0] w_rd_next;

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry_q
        assign w_q_addr[e*ADDR_W +: ADDR_W] = ADDR_W'(e);
    end
    assign w_q_addr[DEPTH*ADDR_W +: NUM_RD*ADDR_W] = rd_addr;

    rf_write_resolve #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR),
        .NUM_Q  (NUM_Q)
    ) u_resolve (
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_q_addr  (w_q_addr),
        .o_q_hit   (w_q_hit),
        .o_q_data  (w_q_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_mem[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (w_q_hit[e] && !(ZERO_REG && e == 0)) begin
                    r_mem[e] <= w_q_data[e*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Out-of-range and zero-register reads return 0 and never see the bypass.
    always_comb begin
        w_rd_next = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (({1'b0, rd_addr[i*ADDR_W +: ADDR_W]} < DEPTH_L) &&
                !(ZERO_REG && (rd_addr[i*ADDR_W +: ADDR_W] == '0))) begin
                if (BYPASS && w_q_hit[DEPTH+i]) begin
                    w_rd_next[i*DATA_W +: DATA_W] = w_q_data[(DEPTH+i)*DATA_W +: DATA_W];
                end else begin
                    w_rd_next[i*DATA_W +: DATA_W] = r_mem[rd_addr[i*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (rd_en[i]) begin
                    r_rd_data[i*DATA_W +: DATA_W] <= w_rd_next[i*DATA_W +: DATA_W];
                end
            end
            r_rd_valid <= rd_en;
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench driving two configurations of register_file_mp from one stimulus
// stream and checking both against an array-based reference model.
module tb_register_file_mp;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NR = 4;
    localparam int NW = 2;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     rd_en;
    logic [NR*AW-1:0]  rd_addr;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;
    logic [NR*DW-1:0]  rd_data_a, rd_data_b;
    logic [NR-1:0]     rd_valid_a, rd_valid_b;

    int checks = 0;
    int errors = 0;

    // A: full depth, zero register, write-first.  B: depth 40, no zero register, read-first.
    register_file_mp #(
        .DATA_W(DW), .DEPTH(64), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    register_file_mp #(
        .DATA_W(DW), .DEPTH(40), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1'b0), .BYPASS(1'b0)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int        m_depth [2] = '{64, 40};
    bit        m_zero  [2] = '{1'b1, 1'b0};
    bit        m_byp   [2] = '{1'b1, 1'b0};
    logic [DW-1:0] m_mem [2][64];
    logic [DW-1:0] m_rd  [2][NR];
    logic          m_vld [2][NR];

    always @(posedge clk or negedge rst_n) begin : model
        int a;
        logic [DW-1:0] d;
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                for (int e = 0; e < 64; e++) m_mem[m][e] = '0;
                for (int i = 0; i < NR; i++) begin
                    m_rd[m][i]  = '0;
                    m_vld[m][i] = 1'b0;
                end
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < NR; i++) begin
                    m_vld[m][i] = rd_en[i];
                    if (rd_en[i]) begin
                        a = int'(rd_addr[i*AW +: AW]);
                        d = '0;
                        if (a < m_depth[m] && !(m_zero[m] && a == 0)) begin
                            d = m_mem[m][a];
                            if (m_byp[m])
                                for (int j = 0; j < NW; j++)
                                    if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a)
                                        d = wr_data[j*DW +: DW];
                        end
                        m_rd[m][i] = d;
                    end
                end
                for (int j = 0; j < NW; j++) begin
                    a = int'(wr_addr[j*AW +: AW]);
                    if (wr_en[j] && a < m_depth[m] && !(m_zero[m] && a == 0))
                        m_mem[m][a] = wr_data[j*DW +: DW];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NR; i++) begin
                chk($sformatf("A.rd_valid[%0d]", i), 64'(rd_valid_a[i]), 64'(m_vld[0][i]));
                chk($sformatf("A.rd_data[%0d]", i), 64'(rd_data_a[i*DW +: DW]), 64'(m_rd[0][i]));
                chk($sformatf("B.rd_valid[%0d]", i), 64'(rd_valid_b[i]), 64'(m_vld[1][i]));
                chk($sformatf("B.rd_data[%0d]", i), 64'(rd_data_b[i*DW +: DW]), 64'(m_rd[1][i]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input int p, input int addr, input logic [DW-1:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = AW'(addr);
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic rd(input int p, input int addr);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = AW'(addr);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        rd_en = '0;
        wr_en = '0;
    endtask

    function automatic logic [63:0] da(input int p);
        return 64'(rd_data_a[p*DW +: DW]);
    endfunction

    function automatic logic [63:0] db(input int p);
        return 64'(rd_data_b[p*DW +: DW]);
    endfunction

    initial begin
        rst_n = 1'b0;
        rd_en = '0; rd_addr = '0;
        wr_en = '0; wr_addr = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        chk("reset.valid_a", 64'(rd_valid_a), 64'h0);
        chk("reset.data_b", 64'(rd_data_b[DW-1:0]), 64'h0);
        rst_n = 1'b1;

        // Reset clears contents and outputs asynchronously
        wr(0, 1, 32'd3); wr(1, 2, 32'd5); tick();
        rd(0, 1); rd(1, 2); tick();
        chk("pre_reset.a0", da(0), 64'd3);
        chk("pre_reset.b1", db(1), 64'd5);
        chk("pre_reset.valid", 64'(rd_valid_a), 64'h3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset.data_a", 64'(rd_data_a[2*DW-1:0]), 64'h0);
        chk("async_reset.valid_a", 64'(rd_valid_a), 64'h0);
        chk("async_reset.valid_b", 64'(rd_valid_b), 64'h0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        rd(0, 1); rd(1, 2); tick();
        chk("post_reset.a0", da(0), 64'd0);
        chk("post_reset.b1", db(1), 64'd0);

        // Basic one-cycle latency and hold
        wr(0, 5, 32'hDEAD); tick();
        rd(0, 5); tick();
        chk("latency.data", da(0), 64'hDEAD);
        chk("latency.valid", 64'(rd_valid_a[0]), 64'd1);
        tick();
        chk("hold.valid", 64'(rd_valid_a[0]), 64'd0);
        chk("hold.data", da(0), 64'hDEAD);

        // Bypass vs read-first
        wr(0, 7, 32'h11); tick();
        wr(0, 7, 32'h22); rd(0, 7); tick();
        chk("bypass.a", da(0), 64'h22);
        chk("readfirst.b", db(0), 64'h11);
        rd(0, 7); tick();
        chk("after_bypass.b", db(0), 64'h22);

        // Multi-write conflict: highest port wins
        wr(0, 9, 32'hAA); wr(1, 9, 32'hBB); rd(0, 9); tick();
        chk("conflict_bypass.a", da(0), 64'hBB);
        chk("conflict_readfirst.b", db(0), 64'h0);
        rd(0, 9); tick();
        chk("conflict.a", da(0), 64'hBB);
        chk("conflict.b", db(0), 64'hBB);

        // Zero register and depth limit
        wr(0, 0, 32'hFF); tick();
        rd(0, 0); tick();
        chk("zero.a", da(0), 64'h0);
        chk("zero.b", db(0), 64'hFF);
        wr(0, 0, 32'h77); rd(1, 0); tick();
        chk("zero_nobypass.a", da(1), 64'h0);
        wr(0, 45, 32'h45); wr(1, 39, 32'h39); tick();
        rd(0, 45); rd(1, 39); tick();
        chk("range.a45", da(0), 64'h45);
        chk("range.b45", db(0), 64'h0);
        chk("range.b39", db(1), 64'h39);

        // Four ports on one edge
        wr(0, 1, 32'h101); wr(1, 2, 32'h202); tick();
        wr(0, 63, 32'h63); tick();
        rd(0, 1); rd(1, 2); rd(2, 2); rd(3, 63); tick();
        chk("multi.a0", da(0), 64'h101);
        chk("multi.a1", da(1), 64'h202);
        chk("multi.a2", da(2), 64'h202);
        chk("multi.a3", da(3), 64'h63);
        chk("multi.valid", 64'(rd_valid_a), 64'hF);
        chk("multi.b3", db(3), 64'h0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
